// File: rtl/address_decoder_pipe.sv
// APB slave-select decoder: captures an address, matches it against inclusive base/limit
// regions with lowest-index priority, and holds the registered selection until xfer_done.
module address_decoder_pipe #(
  parameter int c_apb_num_slaves = 1,
  parameter int c_addr_width     = 32,
  parameter logic [c_apb_num_slaves*c_addr_width-1:0] memory_regions1 = '0,
  parameter logic [c_apb_num_slaves*c_addr_width-1:0] memory_regions2 =
    {{(c_apb_num_slaves*c_addr_width-7){1'b0}}, 7'd64},
  parameter int c_err_cnt_width  = 8
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [c_addr_width-1:0]     req_addr,
  input  logic                        xfer_done,
  output logic                        sel_valid,
  output logic [c_apb_num_slaves-1:0] slave_sel,
  output logic                        dec_error,
  output logic                        multi_hit,
  output logic [c_err_cnt_width-1:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [c_err_cnt_width-1:0] c_cnt_one = {{(c_err_cnt_width-1){1'b0}}, 1'b1};
  localparam logic [c_err_cnt_width-1:0] c_cnt_max = '1;

  state_t                        r_state;
  logic [c_addr_width-1:0]       r_addr;
  logic                          r_req_ready;
  logic                          r_sel_valid;
  logic [c_apb_num_slaves-1:0]   r_slave_sel;
  logic                          r_dec_error;
  logic                          r_multi_hit;
  logic [c_err_cnt_width-1:0]    r_err_count;

  logic [c_apb_num_slaves-1:0]   w_hit;
  logic [c_apb_num_slaves-1:0]   w_first;
  logic                          w_none;
  logic                          w_multi;

  function automatic logic [c_apb_num_slaves-1:0] lowest_set(input logic [c_apb_num_slaves-1:0] v);
    logic [c_apb_num_slaves-1:0] res;
    logic                        found;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < c_apb_num_slaves; i++) begin
      if (v[i] && !found) begin
        res[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic more_than_one(input logic [c_apb_num_slaves-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < c_apb_num_slaves; i++) begin
      if (v[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return multi;
  endfunction

  // A region whose base exceeds its limit can never satisfy both compares, so it never hits.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < c_apb_num_slaves; i++) begin
      w_hit[i] = (r_addr >= memory_regions1[c_addr_width*i +: c_addr_width]) &&
                 (r_addr <= memory_regions2[c_addr_width*i +: c_addr_width]);
    end
  end

  assign w_first = lowest_set(w_hit);
  assign w_none  = ~|w_hit;
  assign w_multi = more_than_one(w_hit);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_req_ready <= 1'b0;
      r_sel_valid <= 1'b0;
      r_slave_sel <= '0;
      r_dec_error <= 1'b0;
      r_multi_hit <= 1'b0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // req_ready is low for the first cycle out of reset, so nothing is accepted then.
          if (r_req_ready && req_valid) begin
            r_addr      <= req_addr;
            r_req_ready <= 1'b0;
            r_state     <= DECODE;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        DECODE: begin
          r_sel_valid <= 1'b1;
          r_slave_sel <= w_first;
          r_dec_error <= w_none;
          r_multi_hit <= w_multi;
          r_state     <= HOLD;
          if (w_none && (r_err_count != c_cnt_max)) begin
            r_err_count <= r_err_count + c_cnt_one;
          end
        end
        HOLD: begin
          if (xfer_done) begin
            r_sel_valid <= 1'b0;
            r_slave_sel <= '0;
            r_dec_error <= 1'b0;
            r_multi_hit <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b0;
          r_sel_valid <= 1'b0;
          r_slave_sel <= '0;
          r_dec_error <= 1'b0;
          r_multi_hit <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign sel_valid = r_sel_valid;
  assign slave_sel = r_slave_sel;
  assign dec_error = r_dec_error;
  assign multi_hit = r_multi_hit;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_address_decoder_pipe.sv
// Scoreboard bench for address_decoder_pipe: random and directed requests, region model
// evaluated from the base/limit tables, monitor comparing every held selection cycle.
module tb_address_decoder_pipe;

  localparam int N  = 6;
  localparam int AW = 16;
  localparam int EW = 2;
  localparam logic [N*AW-1:0] P_BASE = {16'h9000, 16'h8080, 16'h8000, 16'h2000, 16'h1000, 16'h0000};
  localparam logic [N*AW-1:0] P_LIM  = {16'h8FFF, 16'h81FF, 16'h80FF, 16'h2FFF, 16'h1FFF, 16'h0FFF};

  logic [AW-1:0] base_a [N] = '{16'h0000, 16'h1000, 16'h2000, 16'h8000, 16'h8080, 16'h9000};
  logic [AW-1:0] lim_a  [N] = '{16'h0FFF, 16'h1FFF, 16'h2FFF, 16'h80FF, 16'h81FF, 16'h8FFF};

  logic          ACLK;
  logic          ARESET;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          xfer_done;
  logic          sel_valid;
  logic [N-1:0]  slave_sel;
  logic          dec_error;
  logic          multi_hit;
  logic [EW-1:0] err_count;

  address_decoder_pipe #(
    .c_apb_num_slaves(N),
    .c_addr_width(AW),
    .memory_regions1(P_BASE),
    .memory_regions2(P_LIM),
    .c_err_cnt_width(EW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .xfer_done(xfer_done), .sel_valid(sel_valid),
    .slave_sel(slave_sel), .dec_error(dec_error), .multi_hit(multi_hit),
    .err_count(err_count)
  );

  typedef struct {
    logic [N-1:0]  sel;
    logic          err;
    logic          multi;
    logic [EW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   model_cnt = 0;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: scan every region, first hit wins, count hits for overlap.
  function automatic exp_t model(input logic [AW-1:0] a);
    exp_t e;
    int   hits;
    hits  = 0;
    e.sel = '0;
    for (int i = 0; i < N; i++) begin
      if (a >= base_a[i] && a <= lim_a[i]) begin
        if (hits == 0) e.sel[i] = 1'b1;
        hits++;
      end
    end
    e.err   = (hits == 0);
    e.multi = (hits > 1);
    e.cnt   = '0;
    return e;
  endfunction

  always @(posedge ACLK) begin
    if (!ARESET && req_valid && req_ready) acc_q.push_back(cyc);
    cyc++;
  end

  // Monitor: pop on the first valid cycle, then hold the same expectation while valid stays up.
  exp_t cur;
  bit   prev_sv = 1'b0;
  always @(negedge ACLK) begin
    if (ARESET) begin
      prev_sv = 1'b0;
    end else if (sel_valid) begin
      if (!prev_sv) begin
        if (exp_q.size() == 0) check("sb_unexpected_sel", 32'd1, 32'd0);
        else cur = exp_q.pop_front();
      end
      check("slave_sel", slave_sel, cur.sel);
      check("dec_error", dec_error, cur.err);
      check("multi_hit", multi_hit, cur.multi);
      check("err_count", err_count, cur.cnt);
      prev_sv = 1'b1;
    end else begin
      prev_sv = 1'b0;
    end
  end

  task automatic issue(input logic [AW-1:0] a);
    exp_t e;
    int   n;
    req_addr  = a;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    e = model(a);
    if (e.err && model_cnt < 3) model_cnt++;
    e.cnt = EW'(model_cnt);
    exp_q.push_back(e);
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic wait_sel();
    int n;
    n = 0;
    while (!sel_valid && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!sel_valid) check("sel_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_xfer(input int hold, input bit b2b);
    for (int k = 0; k < hold; k++) begin
      req_addr = AW'($urandom);
      @(negedge ACLK);
    end
    xfer_done = 1'b1;
    if (!b2b) req_valid = 1'b0;
    @(negedge ACLK);
    xfer_done = 1'b0;
    check("clr_sel_valid", sel_valid, 32'd0);
    check("clr_slave_sel", slave_sel, 32'd0);
    check("clr_dec_error", dec_error, 32'd0);
    check("clr_multi_hit", multi_hit, 32'd0);
    check("ready_after_done", req_ready, 32'd1);
  endtask

  task automatic run(input logic [AW-1:0] a, input int hold, input bit b2b);
    issue(a);
    wait_sel();
    finish_xfer(hold, b2b);
  endtask

  logic [AW-1:0] dir_addrs [10] = '{16'h1804, 16'h0FFF, 16'h1000, 16'h2FFF, 16'h3000,
                                   16'h8090, 16'h8150, 16'h9000, 16'h8FFF, 16'hFFFF};

  initial begin
    int n;
    int sel;
    int k;
    ARESET    = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    xfer_done = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_req_ready", req_ready, 32'd0);
    check("rst_sel_valid", sel_valid, 32'd0);
    check("rst_slave_sel", slave_sel, 32'd0);
    check("rst_dec_error", dec_error, 32'd0);
    check("rst_multi_hit", multi_hit, 32'd0);
    check("rst_err_count", err_count, 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("ready_after_reset", req_ready, 32'd1);

    // Basic, boundary, overlap, inverted-region and saturation addresses.
    foreach (dir_addrs[i]) run(dir_addrs[i], i % 3, 1'b0);
    run(16'h4000, 0, 1'b0);

    // xfer_done while idle must not disturb anything.
    xfer_done = 1'b1;
    @(negedge ACLK);
    xfer_done = 1'b0;
    check("idle_done_ready", req_ready, 32'd1);
    check("idle_done_sel_valid", sel_valid, 32'd0);

    // xfer_done during DECODE is ignored; selection must still appear and hold.
    issue(16'h2004);
    xfer_done = 1'b1;
    @(negedge ACLK);
    xfer_done = 1'b0;
    wait_sel();
    finish_xfer(1, 1'b0);

    // req_valid held high, done in first hold cycle: one accept every 3 cycles.
    for (int i = 0; i < 5; i++) run(16'h0100 + AW'(i) * 16'h1000, 0, (i < 4));
    n = acc_q.size();
    for (int i = n - 4; i < n; i++) check("b2b_accept_gap", acc_q[i] - acc_q[i-1], 32'd3);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      k   = $urandom_range(0, N - 1);
      if (sel == 0) req_addr = AW'($urandom);
      else if (sel == 1) req_addr = base_a[k] + AW'($urandom_range(0, 2)) - 16'd1;
      else req_addr = lim_a[k] + AW'($urandom_range(0, 2)) - 16'd1;
      run(req_addr, $urandom_range(0, 2), (i != 39) && ($urandom_range(0, 1) == 1));
    end

    // Asynchronous reset while holding slave 1.
    issue(16'h1804);
    wait_sel();
    check("pre_rst_slave_sel", slave_sel, 32'h2);
    #2 ARESET = 1'b1;
    req_valid = 1'b0;
    #1;
    check("arst_sel_valid", sel_valid, 32'd0);
    check("arst_slave_sel", slave_sel, 32'd0);
    check("arst_dec_error", dec_error, 32'd0);
    check("arst_multi_hit", multi_hit, 32'd0);
    check("arst_err_count", err_count, 32'd0);
    check("arst_req_ready", req_ready, 32'd0);
    model_cnt = 0;
    exp_q.delete();
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("ready_after_arst", req_ready, 32'd1);
    check("cnt_after_arst", err_count, 32'd0);
    run(16'h3000, 1, 1'b0);

    check("sb_leftover", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
